// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//   Turns four debounced button levels into SHORT / LONG / REPEAT events for
//   one button at a time, delivered over a valid/ready handshake.
//
//   Parameters
//     CLK_DIV    clk cycles per timing tick (>= 2)
//     LONG_TICKS ticks of continuous hold before a LONG event (>= 1)
//     RPT_TICKS  ticks between REPEAT events while held (>= 1)
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     btn_lvl    [3:0] button levels, synchronous to clk, 1 = pressed
//     evt_valid  event pending
//     evt_ready  consumer accepts the pending event this cycle
//     evt_btn    [1:0] index of the button owning the event
//     evt_type   [1:0] 00 SHORT, 01 LONG, 10 REPEAT
//     evt_drop   one-cycle pulse when a generated event is lost
//     busy       high whenever the FSM is not idle
module btn_event_ctrl #(
  parameter int CLK_DIV    = 100000,
  parameter int LONG_TICKS = 1000,
  parameter int RPT_TICKS  = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_lvl,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [1:0] evt_btn,
  output logic [1:0] evt_type,
  output logic       evt_drop,
  output logic       busy
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam int RW = $clog2(RPT_TICKS + 1);

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
  localparam logic [RW-1:0] RPT_LAST  = RW'(RPT_TICKS - 1);
  localparam logic [RW-1:0] RPT_MAX   = RW'(RPT_TICKS);

  localparam logic [1:0] EVT_SHORT  = 2'b00;
  localparam logic [1:0] EVT_LONG   = 2'b01;
  localparam logic [1:0] EVT_REPEAT = 2'b10;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, WAIT_REL} state_t;

  state_t          state;
  state_t          nxt;
  logic [1:0]      cap_idx;
  logic [PW-1:0]   presc;
  logic [HW-1:0]   hold_cnt;
  logic [RW-1:0]   rpt_cnt;

  logic            tick;
  logic            cap_lvl;
  logic            gen;
  logic [1:0]      gen_type;

  // Lowest index wins when several buttons go down together.
  function automatic logic [1:0] first_set(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // Next-state and event generation. Release is tested first in PRESS and
  // HELD so it overrides a coinciding LONG or REPEAT threshold.
  always_comb begin
    tick     = (presc == PRESC_MAX);
    cap_lvl  = btn_lvl[cap_idx];
    gen      = 1'b0;
    gen_type = EVT_SHORT;
    nxt      = state;
    case (state)
      IDLE: begin
        if (|btn_lvl) nxt = PRESS;
      end
      PRESS: begin
        if (!cap_lvl) begin
          nxt      = WAIT_REL;
          gen      = 1'b1;
          gen_type = EVT_SHORT;
        end else if (tick && (hold_cnt == HOLD_LAST)) begin
          nxt      = HELD;
          gen      = 1'b1;
          gen_type = EVT_LONG;
        end
      end
      HELD: begin
        if (!cap_lvl) begin
          nxt = WAIT_REL;
        end else if (tick && (rpt_cnt == RPT_LAST)) begin
          gen      = 1'b1;
          gen_type = EVT_REPEAT;
        end
      end
      WAIT_REL: begin
        if (btn_lvl == 4'b0000) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      cap_idx   <= 2'd0;
      presc     <= '0;
      hold_cnt  <= '0;
      rpt_cnt   <= '0;
      evt_valid <= 1'b0;
      evt_btn   <= 2'b00;
      evt_type  <= 2'b00;
      evt_drop  <= 1'b0;
    end else begin
      state    <= nxt;
      busy     <= (nxt != IDLE);
      evt_drop <= 1'b0;

      // Output slot: a new event loads if the slot is free or being emptied
      // this cycle; otherwise it is lost and flagged.
      if (gen) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_btn   <= cap_idx;
          evt_type  <= gen_type;
        end else begin
          evt_drop  <= 1'b1;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (|btn_lvl) cap_idx <= first_set(btn_lvl);
          presc    <= '0;
          hold_cnt <= '0;
          rpt_cnt  <= '0;
        end
        PRESS: begin
          if (nxt == HELD) begin
            presc   <= '0;
            rpt_cnt <= '0;
          end else if (nxt == PRESS) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + HW'(1);
          end
        end
        HELD: begin
          if (nxt == HELD) begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && (rpt_cnt == RPT_LAST))   rpt_cnt <= '0;
            else if (tick && (rpt_cnt != RPT_MAX)) rpt_cnt <= rpt_cnt + RW'(1);
          end
        end
        WAIT_REL: begin
          presc <= '0;
        end
        default: begin
          presc <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl with CLK_DIV=4, LONG_TICKS=3, RPT_TICKS=2.
// Edge numbering: edge 0 is the first rising edge that samples a new press.
module tb_btn_event_ctrl;

  localparam int DIV  = 4;
  localparam int LT   = 3;
  localparam int RT   = 2;
  localparam int LONG_E = LT * DIV;   // 12
  localparam int RPT_E  = RT * DIV;   // 8

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_btn;
  logic [1:0] evt_type;
  logic       evt_drop;
  logic       busy;

  btn_event_ctrl #(.CLK_DIV(DIV), .LONG_TICKS(LT), .RPT_TICKS(RT)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_lvl   (btn_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_btn   (evt_btn),
    .evt_type  (evt_type),
    .evt_drop  (evt_drop),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    int         cyc;
    logic [1:0] btn;
    logic [1:0] typ;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic [3:0] lvl;
    int         rel;   // edge at which the release is sampled
  } vec_t;
  vec_t tab[7];

  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return 2'(b);
    return 2'd0;
  endfunction

  // Expected events of one press held from edge 0 until its release is
  // sampled at edge rel.
  task automatic push_events(input logic [3:0] lvl, input int rel, input int cap);
    exp_t e;
    e.btn = low_idx(lvl);
    if (rel <= LONG_E) begin
      e.cyc = cap + rel; e.typ = 2'b00; exp_q.push_back(e);
    end else begin
      e.cyc = cap + LONG_E; e.typ = 2'b01; exp_q.push_back(e);
      for (int t = LONG_E + RPT_E; t < rel; t += RPT_E) begin
        e.cyc = cap + t; e.typ = 2'b10; exp_q.push_back(e);
      end
    end
  endtask

  // Scoreboard: every event seen on the output must be the next expected one.
  always @(negedge clk) begin
    if (mon_en && !rst && evt_valid) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_event: got btn %0d type %0d at cycle %0d, expected none",
                 evt_btn, evt_type, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("evt_cycle", 32'(cyc), 32'(e.cyc));
        chk("evt_btn", 32'(evt_btn), 32'(e.btn));
        chk("evt_type", 32'(evt_type), 32'(e.typ));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  int cap;

  initial begin
    tab[0] = '{4'b0010, 5};    // SHORT btn 1
    tab[1] = '{4'b0001, 30};   // LONG 12, REPEAT 20, 28
    tab[2] = '{4'b0100, 12};   // release coincides with LONG threshold
    tab[3] = '{4'b1000, 13};   // LONG only
    tab[4] = '{4'b0110, 20};   // release coincides with REPEAT
    tab[5] = '{4'b0011, 1};    // quick SHORT, btn 0 wins
    tab[6] = '{4'b1100, 21};   // btn 2 LONG + REPEAT

    rst = 1'b1;
    btn_lvl = 4'b0000;
    evt_ready = 1'b1;
    #3;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_btn", 32'(evt_btn), 0);
    chk("rst_type", 32'(evt_type), 0);
    chk("rst_drop", 32'(evt_drop), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Table-driven presses
    for (int i = 0; i < 7; i++) begin
      btn_lvl = tab[i].lvl;
      cap = cyc + 1;
      push_events(tab[i].lvl, tab[i].rel, cap);
      @(negedge clk);
      chk("busy_after_capture", 32'(busy), 1);
      repeat (tab[i].rel - 1) @(negedge clk);
      btn_lvl = 4'b0000;
      repeat (2) @(negedge clk);
      chk("busy_after_release", 32'(busy), 0);
      @(negedge clk);
    end

    // Non-captured button keeps the FSM in WAIT_REL and never reports
    btn_lvl = 4'b1010;
    cap = cyc + 1;
    push_events(4'b0010, 4, cap);
    @(negedge clk);
    repeat (3) @(negedge clk);
    btn_lvl = 4'b1000;
    repeat (4) @(negedge clk);
    chk("busy_wait_rel", 32'(busy), 1);
    btn_lvl = 4'b0000;
    repeat (2) @(negedge clk);
    chk("busy_after_bit3", 32'(busy), 0);
    @(negedge clk);

    // Back-pressure: LONG held pending, REPEAT dropped
    mon_en = 1'b0;
    evt_ready = 1'b0;
    btn_lvl = 4'b0100;
    cap = cyc + 1;
    repeat (13) @(negedge clk);
    chk("bp_long_valid", 32'(evt_valid), 1);
    chk("bp_long_type", 32'(evt_type), 1);
    chk("bp_long_btn", 32'(evt_btn), 2);
    repeat (8) @(negedge clk);
    chk("bp_drop_pulse", 32'(evt_drop), 1);
    chk("bp_type_stable", 32'(evt_type), 1);
    @(negedge clk);
    chk("bp_drop_cleared", 32'(evt_drop), 0);
    chk("bp_still_valid", 32'(evt_valid), 1);
    btn_lvl = 4'b0000;
    repeat (3) @(negedge clk);
    chk("bp_idle", 32'(busy), 0);
    chk("bp_pending", 32'(evt_valid), 1);
    chk("bp_type_held", 32'(evt_type), 1);
    evt_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", 32'(evt_valid), 0);
    @(negedge clk);
    mon_en = 1'b1;

    // Reset in the middle of a press, button still held afterwards
    btn_lvl = 4'b0001;
    cap = cyc + 1;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_valid", 32'(evt_valid), 0);
    chk("midrst_drop", 32'(evt_drop), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cap = cyc + 1;
    push_events(4'b0001, 14, cap);
    @(negedge clk);
    chk("post_rst_capture", 32'(busy), 1);
    repeat (13) @(negedge clk);
    btn_lvl = 4'b0000;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 0);

    repeat (4) @(negedge clk);
    chk("events_outstanding", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
